// File: rtl/systolic_tile_scheduler.sv
// systolic_tile_scheduler: runs one M x M matrix-multiply tile through the
// output-stationary PE grid. It clears the accumulators, streams M operand
// vectors from the activation/weight buffers into the array edges with a
// diagonal skew, lets the wavefront flush, then drains one result row per
// valid/ready beat.
module systolic_tile_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int M          = 3,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [ADDR_WIDTH-1:0]        cmd_base_a,
  input  logic [ADDR_WIDTH-1:0]        cmd_base_w,
  output logic                         buf_rd_en,
  output logic [ADDR_WIDTH-1:0]        buf_rd_addr_a,
  output logic [ADDR_WIDTH-1:0]        buf_rd_addr_w,
  input  logic [M*DATA_WIDTH-1:0]      buf_rd_data_a,
  input  logic [M*DATA_WIDTH-1:0]      buf_rd_data_w,
  output logic                         arr_clear,
  output logic [M*DATA_WIDTH-1:0]      arr_act,
  output logic [M*DATA_WIDTH-1:0]      arr_wgt,
  input  logic [M*M*DATA_WIDTH-1:0]    arr_result,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [M*DATA_WIDTH-1:0]      res_data,
  output logic [((M > 1) ? $clog2(M) : 1)-1:0] res_row,
  output logic                         busy,
  output logic                         done
);

  localparam int ROW_W        = (M > 1) ? $clog2(M) : 1;
  localparam int FLUSH_CYCLES = 3 * M;
  localparam int CNT_W        = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    FLUSH,
    DRAIN
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base_a;
  logic [ADDR_WIDTH-1:0] base_w;
  logic [CNT_W-1:0]      cnt;
  logic                  rd_valid;

  // The done cycle still counts as unavailable so a held command lands one cycle later
  assign cmd_ready = (state == IDLE) && !done;
  assign busy      = (state != IDLE);

  // Tile sequencer: command capture, clear pulse, operand reads, flush wait and row drain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      base_a        <= '0;
      base_w        <= '0;
      cnt           <= '0;
      arr_clear     <= 1'b0;
      buf_rd_en     <= 1'b0;
      buf_rd_addr_a <= '0;
      buf_rd_addr_w <= '0;
      res_valid     <= 1'b0;
      res_row       <= '0;
      done          <= 1'b0;
    end else begin
      arr_clear <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            base_a    <= cmd_base_a;
            base_w    <= cmd_base_w;
            arr_clear <= 1'b1;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          buf_rd_en     <= 1'b1;
          buf_rd_addr_a <= base_a;
          buf_rd_addr_w <= base_w;
          cnt           <= '0;
          state         <= LOAD;
        end
        LOAD: begin
          if (cnt == CNT_W'(M - 1)) begin
            buf_rd_en <= 1'b0;
            cnt       <= '0;
            state     <= FLUSH;
          end else begin
            cnt           <= cnt + CNT_W'(1);
            buf_rd_addr_a <= buf_rd_addr_a + ADDR_WIDTH'(1);
            buf_rd_addr_w <= buf_rd_addr_w + ADDR_WIDTH'(1);
          end
        end
        FLUSH: begin
          if (cnt == CNT_W'(FLUSH_CYCLES - 1)) begin
            cnt       <= '0;
            res_valid <= 1'b1;
            res_row   <= '0;
            state     <= DRAIN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (res_ready) begin
            if (res_row == ROW_W'(M - 1)) begin
              res_valid <= 1'b0;
              res_row   <= '0;
              done      <= 1'b1;
              state     <= IDLE;
            end else begin
              res_row <= res_row + ROW_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Marks the cycle in which buffer read data is valid (one cycle after the strobe)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= buf_rd_en;
    end
  end

  // Lane i gets i+1 register stages so the operands enter the grid as a diagonal wavefront
  for (genvar i = 0; i < M; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] act_pipe [0:i];
    logic [DATA_WIDTH-1:0] wgt_pipe [0:i];

    // Shift the lane's operand through its skew stages, injecting zeros outside the read window
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int s = 0; s <= i; s++) begin
          act_pipe[s] <= '0;
          wgt_pipe[s] <= '0;
        end
      end else begin
        act_pipe[0] <= rd_valid ? buf_rd_data_a[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        wgt_pipe[0] <= rd_valid ? buf_rd_data_w[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int s = 1; s <= i; s++) begin
          act_pipe[s] <= act_pipe[s-1];
          wgt_pipe[s] <= wgt_pipe[s-1];
        end
      end
    end

    assign arr_act[i*DATA_WIDTH +: DATA_WIDTH] = act_pipe[i];
    assign arr_wgt[i*DATA_WIDTH +: DATA_WIDTH] = wgt_pipe[i];
  end

  // Present the selected result row straight from the array; zero whenever no beat is offered
  always_comb begin
    res_data = '0;
    for (int j = 0; j < M; j++) begin
      if (res_valid) begin
        res_data[j*DATA_WIDTH +: DATA_WIDTH] =
          arr_result[(int'(res_row) * M + j) * DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// tb_systolic_tile_scheduler: directed bench with an operand-buffer model and
// an output-stationary PE-grid model around the scheduler; checks timing,
// addresses, handshakes and the resulting matrix rows.
module tb_systolic_tile_scheduler;

  localparam int DW = 32;
  localparam int M  = 3;
  localparam int AW = 8;

  logic              clk;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [AW-1:0]     cmd_base_a;
  logic [AW-1:0]     cmd_base_w;
  logic              buf_rd_en;
  logic [AW-1:0]     buf_rd_addr_a;
  logic [AW-1:0]     buf_rd_addr_w;
  logic [M*DW-1:0]   buf_rd_data_a;
  logic [M*DW-1:0]   buf_rd_data_w;
  logic              arr_clear;
  logic [M*DW-1:0]   arr_act;
  logic [M*DW-1:0]   arr_wgt;
  logic [M*M*DW-1:0] arr_result;
  logic              res_valid;
  logic              res_ready;
  logic [M*DW-1:0]   res_data;
  logic [1:0]        res_row;
  logic              busy;
  logic              done;

  int checks   = 0;
  int failures = 0;

  logic [M*DW-1:0] mem_a [0:255];
  logic [M*DW-1:0] mem_w [0:255];
  logic [DW-1:0]   a_reg [3][3];
  logic [DW-1:0]   w_reg [3][3];
  logic [DW-1:0]   acc   [3][3];

  int mat_id [9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
  int mat_b  [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
  int mat_bb [9] = '{30, 36, 42, 66, 81, 96, 102, 126, 150};

  systolic_tile_scheduler #(.DATA_WIDTH(DW), .M(M), .ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_base_a    (cmd_base_a),
    .cmd_base_w    (cmd_base_w),
    .buf_rd_en     (buf_rd_en),
    .buf_rd_addr_a (buf_rd_addr_a),
    .buf_rd_addr_w (buf_rd_addr_w),
    .buf_rd_data_a (buf_rd_data_a),
    .buf_rd_data_w (buf_rd_data_w),
    .arr_clear     (arr_clear),
    .arr_act       (arr_act),
    .arr_wgt       (arr_wgt),
    .arr_result    (arr_result),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .res_row       (res_row),
    .busy          (busy),
    .done          (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Operand buffers with one cycle of read latency
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_rd_data_a <= '0;
      buf_rd_data_w <= '0;
    end else if (buf_rd_en) begin
      buf_rd_data_a <= mem_a[buf_rd_addr_a];
      buf_rd_data_w <= mem_w[buf_rd_addr_w];
    end
  end

  function automatic logic [DW-1:0] pe_a(int i, int j);
    if (j == 0) return arr_act[i*DW +: DW];
    return a_reg[i][j-1];
  endfunction

  function automatic logic [DW-1:0] pe_w(int i, int j);
    if (i == 0) return arr_wgt[j*DW +: DW];
    return w_reg[i-1][j];
  endfunction

  // PE grid: activations flow east, weights flow south, each PE accumulates in place
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < M; i++)
        for (int j = 0; j < M; j++) begin
          a_reg[i][j] <= '0;
          w_reg[i][j] <= '0;
          acc[i][j]   <= '0;
        end
    end else begin
      for (int i = 0; i < M; i++)
        for (int j = 0; j < M; j++) begin
          a_reg[i][j] <= pe_a(i, j);
          w_reg[i][j] <= pe_w(i, j);
          acc[i][j]   <= arr_clear ? '0 : acc[i][j] + pe_a(i, j) * pe_w(i, j);
        end
    end
  end

  always_comb begin
    arr_result = '0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        arr_result[(i*M+j)*DW +: DW] = acc[i][j];
  end

  task automatic put_a(input logic [AW-1:0] base, input int m [9]);
    logic [M*DW-1:0] vec;
    logic [AW-1:0]   addr;
    for (int k = 0; k < M; k++) begin
      for (int i = 0; i < M; i++) vec[i*DW +: DW] = 32'(m[i*M+k]);
      addr = base + AW'(k);
      mem_a[addr] = vec;
    end
  endtask

  task automatic put_w(input logic [AW-1:0] base, input int m [9]);
    logic [M*DW-1:0] vec;
    logic [AW-1:0]   addr;
    for (int k = 0; k < M; k++) begin
      for (int j = 0; j < M; j++) vec[j*DW +: DW] = 32'(m[k*M+j]);
      addr = base + AW'(k);
      mem_w[addr] = vec;
    end
  endtask

  function automatic logic [M*DW-1:0] row_of(input int m [9], input int r);
    logic [M*DW-1:0] v;
    for (int j = 0; j < M; j++) v[j*DW +: DW] = 32'(m[r*M+j]);
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one tile starting at the current negedge (cycle T); optionally raises the next
  // command during LOAD and holds it so it is waiting when this tile finishes
  task automatic applyStimulus(input logic [AW-1:0] ba, input logic [AW-1:0] bw,
                               input int exp_c [9], input int stall, input bit hold_next,
                               input logic [AW-1:0] nba, input logic [AW-1:0] nbw);
    cmd_valid  = 1'b1;
    cmd_base_a = ba;
    cmd_base_w = bw;
    checkOutput("cmd_ready_idle", 128'(cmd_ready), 128'(1));
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("arr_clear_pulse", 128'(arr_clear), 128'(1));
    checkOutput("busy_clear", 128'(busy), 128'(1));
    checkOutput("cmd_ready_clear", 128'(cmd_ready), 128'(0));
    for (int k = 0; k < M; k++) begin
      @(negedge clk);
      checkOutput("rd_en_load", 128'(buf_rd_en), 128'(1));
      checkOutput("rd_addr_a", 128'(buf_rd_addr_a), 128'(AW'(ba + AW'(k))));
      checkOutput("rd_addr_w", 128'(buf_rd_addr_w), 128'(AW'(bw + AW'(k))));
      checkOutput("arr_clear_load", 128'(arr_clear), 128'(0));
      if (k == 1 && hold_next) begin
        cmd_valid  = 1'b1;
        cmd_base_a = nba;
        cmd_base_w = nbw;
        checkOutput("cmd_ready_load_held", 128'(cmd_ready), 128'(0));
      end
    end
    @(negedge clk);
    checkOutput("rd_en_flush", 128'(buf_rd_en), 128'(0));
    repeat (8) @(negedge clk);
    checkOutput("res_valid_early", 128'(res_valid), 128'(0));
    @(negedge clk);
    for (int r = 0; r < M; r++) begin
      if (stall > 0) begin
        res_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
          checkOutput("stall_valid", 128'(res_valid), 128'(1));
          checkOutput("stall_row", 128'(res_row), 128'(r));
          checkOutput("stall_data", 128'(res_data), 128'(row_of(exp_c, r)));
          @(negedge clk);
        end
        res_ready = 1'b1;
      end
      checkOutput("res_valid", 128'(res_valid), 128'(1));
      checkOutput("res_row", 128'(res_row), 128'(r));
      checkOutput("res_data", 128'(res_data), 128'(row_of(exp_c, r)));
      checkOutput("done_drain", 128'(done), 128'(0));
      if (hold_next) checkOutput("cmd_ready_drain_held", 128'(cmd_ready), 128'(0));
      @(negedge clk);
    end
    checkOutput("done_pulse", 128'(done), 128'(1));
    checkOutput("res_valid_after", 128'(res_valid), 128'(0));
    checkOutput("busy_done", 128'(busy), 128'(0));
    checkOutput("cmd_ready_done", 128'(cmd_ready), 128'(0));
    checkOutput("arr_clear_done", 128'(arr_clear), 128'(0));
    @(negedge clk);
    checkOutput("done_one_cycle", 128'(done), 128'(0));
  endtask

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_base_a = '0;
    cmd_base_w = '0;
    res_ready  = 1'b1;
    for (int a = 0; a < 256; a++) begin
      mem_a[a] = {M{32'hDEAD_0000 + 32'(a)}};
      mem_w[a] = {M{32'hBEEF_0000 + 32'(a)}};
    end
    put_a(8'h10, mat_id);
    put_w(8'h20, mat_b);
    put_a(8'h40, mat_b);
    put_a(8'hFE, mat_b);
    put_w(8'h30, mat_id);

    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 128'(busy), 128'(0));
    checkOutput("rst_rd_en", 128'(buf_rd_en), 128'(0));
    checkOutput("rst_res_valid", 128'(res_valid), 128'(0));
    checkOutput("rst_res_data", 128'(res_data), 128'(0));
    checkOutput("rst_arr_act", 128'(arr_act), 128'(0));
    checkOutput("rst_done", 128'(done), 128'(0));
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_cmd_ready", 128'(cmd_ready), 128'(1));

    $display("[TB] tile 1: identity x W");
    applyStimulus(8'h10, 8'h20, mat_b, 0, 1'b0, 8'h00, 8'h00);

    $display("[TB] tile 2: B x B with next command held from LOAD");
    applyStimulus(8'h40, 8'h20, mat_bb, 0, 1'b1, 8'h10, 8'h20);

    $display("[TB] tile 3: held command, stalled drain");
    applyStimulus(8'h10, 8'h20, mat_b, 5, 1'b0, 8'h00, 8'h00);

    $display("[TB] tile 4: activation base wraps");
    applyStimulus(8'hFE, 8'h30, mat_b, 0, 1'b0, 8'h00, 8'h00);

    $display("[TB] tile 5: reset during LOAD");
    cmd_valid  = 1'b1;
    cmd_base_a = 8'h40;
    cmd_base_w = 8'h20;
    checkOutput("abort_cmd_ready", 128'(cmd_ready), 128'(1));
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("abort_addr_k1", 128'(buf_rd_addr_a), 128'(8'h41));
    reset = 1'b1;
    #1;
    checkOutput("abort_busy", 128'(busy), 128'(0));
    checkOutput("abort_rd_en", 128'(buf_rd_en), 128'(0));
    checkOutput("abort_addr", 128'(buf_rd_addr_a), 128'(0));
    checkOutput("abort_arr_act", 128'(arr_act), 128'(0));
    checkOutput("abort_arr_wgt", 128'(arr_wgt), 128'(0));
    checkOutput("abort_res_valid", 128'(res_valid), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 16; c++) begin
      checkOutput("abort_no_done", 128'(done), 128'(0));
      @(negedge clk);
    end

    $display("[TB] tile 6: identity x W after reset");
    applyStimulus(8'h10, 8'h20, mat_b, 0, 1'b0, 8'h00, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_tile_scheduler.md
Name: systolic_tile_scheduler

Overview:
- Sequences one M x M matrix-multiply tile through the M x M weight/activation systolic PE array.
- On a command it clears the PE accumulators and reads M operand vectors from two on-chip operand buffers (activation and weight).
- It injects the vectors into the array edges with diagonal skew, waits a fixed flush interval, then drains the M x M result one row per beat over a valid/ready stream.
- Sits between the host command interface / operand buffers and the PE grid; it replaces ad-hoc per-lane ready gating.

Parameters:
- DATA_WIDTH, 32, width of each operand and result element.
- M, 3, array dimension (rows = columns = lanes).
- ADDR_WIDTH, 8, operand buffer address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  tile command valid.
- cmd_ready  out  1  scheduler can accept a command.
- cmd_base_a  in  ADDR_WIDTH  activation buffer base address.
- cmd_base_w  in  ADDR_WIDTH  weight buffer base address.
- buf_rd_en  out  1  operand buffer read strobe, shared by both buffers.
- buf_rd_addr_a  out  ADDR_WIDTH  activation buffer read address.
- buf_rd_addr_w  out  ADDR_WIDTH  weight buffer read address.
- buf_rd_data_a  in  M*DATA_WIDTH  activation vector; lane i at [i*DATA_WIDTH +: DATA_WIDTH] = A[i][k]; 1-cycle read latency.
- buf_rd_data_w  in  M*DATA_WIDTH  weight vector; lane j = W[k][j]; 1-cycle read latency.
- arr_clear  out  1  one-cycle pulse that clears all PE accumulators.
- arr_act  out  M*DATA_WIDTH  skewed activations to the array west edge, lane i drives row i.
- arr_wgt  out  M*DATA_WIDTH  skewed weights to the array north edge, lane j drives column j.
- arr_result  in  M*M*DATA_WIDTH  PE results; element (i,j) at [(i*M+j)*DATA_WIDTH +: DATA_WIDTH].
- res_valid  out  1  result row valid.
- res_ready  in  1  result consumer ready.
- res_data  out  M*DATA_WIDTH  result row; lane j = C[row][j].
- res_row  out  $clog2(M)  index of the current result row.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last result beat.

Behaviour:
- Reset values: every output is 0, the FSM is in IDLE, and all skew registers are 0. cmd_ready is 1 combinationally once in IDLE.
- States: IDLE -> CLEAR -> LOAD -> FLUSH -> DRAIN -> IDLE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready at cycle T, latch both base addresses and go to CLEAR.
- CLEAR (cycle T+1): arr_clear = 1 for exactly one cycle, then go to LOAD.
- LOAD (cycles T+2 .. T+M+1), counter k = 0..M-1:
  - buf_rd_en = 1.
  - buf_rd_addr_a = base_a + k and buf_rd_addr_w = base_w + k, each modulo 2^ADDR_WIDTH (wrap, no error).
- Skew:
  - A vector read at cycle c appears on lane i of arr_act/arr_wgt at cycle c+2+i. This is one buffer-latency stage plus i+1 registered stages.
  - Any lane slot not carrying a valid operand drives 0, so the PEs accumulate nothing outside the valid window.
- FLUSH: exactly 3*M cycles (T+M+2 .. T+4M+1), then go to DRAIN.
- DRAIN, first beat at T+4M+2 (T+14 for M=3):
  - res_valid = 1 and res_row = r for r = 0..M-1.
  - res_data is taken directly from arr_result row r; the array holds its results because its inputs are 0.
  - r advances only on res_valid && res_ready. While stalled, res_data and res_row are held stable.
  - The handshake on r = M-1 goes to IDLE, with done = 1 in the following cycle only. res_valid drops the same cycle the last beat completes.
- Arithmetic: C[i][j] = sum over k of A[i][k]*W[k][j], truncated to DATA_WIDTH. Overflow wraps silently; the scheduler does no arithmetic itself.
- Busy/command interaction:
  - busy = (state != IDLE).
  - cmd_valid while busy is ignored (cmd_ready = 0); the command must be held by the source.
  - A new command is accepted at the earliest in the cycle after done.
- Asynchronous reset at any time (including mid-LOAD or mid-DRAIN):
  - Returns immediately to IDLE and zeros all skew registers and outputs.
  - The partial tile is discarded, with no done pulse.
- arr_clear is never asserted outside CLEAR.

Test Plan:
- A = identity and W = [[1,2,3],[4,5,6],[7,8,9]] at bases 0x10/0x20, res_ready always 1 -> rows 1,2,3 / 4,5,6 / 7,8,9 appear on rows 0..2 starting at T+14, then done pulse 1 cycle after the last beat.
- A = [[1,2,3],[4,5,6],[7,8,9]], W = same -> rows 30,36,42 / 66,81,96 / 102,126,150.
- Repeat the identity test with res_ready low for 5 cycles at each beat -> res_data/res_row stable while stalled, each row delivered exactly once, done after row 2.
- Command pulses during LOAD and DRAIN -> cmd_ready = 0, no acceptance, the first tile's result is unaffected; a held command is accepted the cycle after done.
- cmd_base_a = 0xFE -> read addresses 0xFE, 0xFF, 0x00; result matches the wrapped buffer contents.
- Assert reset during LOAD k=1 -> outputs 0, busy 0, no done pulse; the next command produces a correct tile with arr_clear asserted at T+1.
